boolean_table_engine: RTL and testbench
=======================================

BOOLEAN_TABLE_ENGINE -- requirements
Module: boolean_table_engine

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of function inputs (legal 2..6).
REQ-002 SHALL have derived constant TBL_W = 2**N_IN, the truth-table size in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port load_valid, input, 1, meaning a table bit is offered.
REQ-006 SHALL have port load_bit, input, 1, the table bit value, index 0 first.
REQ-007 SHALL have port load_ready, output, 1, meaning the block accepts a table bit this cycle.
REQ-008 SHALL have port x, input, N_IN, the live function inputs; MSB is the first variable.
REQ-009 SHALL have port y, output, 1, the registered function value of x.
REQ-010 SHALL have port start, input, 1, requesting a sweep of all input combinations.
REQ-011 SHALL have port busy, output, 1, meaning the block is in LOAD or SWEEP.
REQ-012 SHALL have port sweep_valid, output, 1, qualifying sweep_idx and sweep_y.
REQ-013 SHALL have port sweep_idx, output, N_IN, the current swept combination.
REQ-014 SHALL have port sweep_y, output, 1, the table value at sweep_idx.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse at sweep end.
REQ-016 SHALL have port minterm_count, output, N_IN+1, the number of 1 entries from the last sweep.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SWEEP and DONE.
REQ-018 SHALL assert load_ready only in IDLE and LOAD.
REQ-019 SHALL, on load_valid in IDLE, accept the bit as index 0 and move to LOAD; each later load_valid&&load_ready beat writes the next index into a shadow table.
REQ-020 SHALL, on accepting the bit at index TBL_W-1, copy the shadow table to the active table in the same edge and return to IDLE.
REQ-021 SHALL leave the active table unchanged until the commit in REQ-020; load gaps (load_valid low) only stall the load.
REQ-022 SHALL register y = active_table[x] with one-cycle latency, in every state, including during LOAD and SWEEP.
REQ-023 SHALL, on start in IDLE with load_valid low, clear the running count, set sweep_idx to 0 and enter SWEEP.
REQ-024 SHALL ignore start outside IDLE; if load_valid and start are both high in IDLE, the load SHALL win.
REQ-025 SHALL hold sweep_valid high for exactly TBL_W consecutive cycles in SWEEP, with sweep_idx = 0..TBL_W-1 and sweep_y = active_table[sweep_idx].
REQ-026 SHALL increment the running count for each swept 1; the count SHALL be N_IN+1 bits so that the all-ones count TBL_W does not wrap.
REQ-027 SHALL, after index TBL_W-1, enter DONE for one cycle, pulse done, update minterm_count, and then return to IDLE.
REQ-028 SHALL keep minterm_count stable except at the DONE update.
REQ-029 SHALL drive busy = (state==LOAD || state==SWEEP).

Reset
REQ-030 SHALL, on rst, enter IDLE and clear the active and shadow tables to 0 (the constant-0 function).
REQ-031 SHALL, on rst, drive y, sweep_valid, sweep_idx, sweep_y, done, busy and minterm_count to 0, with load_ready at 1.
REQ-032 SHALL, on rst during LOAD, discard the partial load; on rst during SWEEP, abort without a done pulse.

Structure
REQ-033 SHALL place the FSM state enum and the TBL_W function in a shared package, bool_pkg.
REQ-034 SHALL keep the table load and commit logic in one sub-module, truth_table_store; the FSM, sweep counter and count logic stay in the top level.

Verification
REQ-035 SHALL test: N_IN=4, load 16'h8934 LSB-first, then x=4'h4 -> y=1 one cycle later; x=4'h3 -> y=0.
REQ-036 SHALL test: after REQ-035, start -> 16 cycles of sweep_valid with sweep_y=1 at idx 2,4,5,8,11,15 only, then done pulse and minterm_count=6.
REQ-037 SHALL test: load all-ones, then sweep -> minterm_count=16 (5'b10000) with no wrap; after reset -> sweep gives count=0.
REQ-038 SHALL test: start with load_valid high in IDLE -> LOAD entered and no sweep; start during SWEEP -> ignored.
REQ-039 SHALL test: rst asserted after 7 load beats -> active table still 0 and y=0; rst mid-sweep -> no done pulse and sweep_valid=0 immediately.
REQ-040 SHALL test: load with random load_valid gaps -> same committed table, and y tracks the old table until the last beat.

Source files
------------

// File: rtl/bool_pkg.sv
// Shared types for the boolean table engine: FSM state encoding and table-size helper.
package bool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SWEEP,
        ST_DONE
    } state_t;

    function automatic int unsigned tbl_w(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_store.sv
// Serial truth-table loader: accepted bits fill a shadow table, which is committed
// to the active table on the edge that accepts the final index.
module truth_table_store
    import bool_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    localparam int unsigned TBL_W = tbl_w(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_accept,
    input  logic             load_bit,
    output logic             commit,
    output logic [TBL_W-1:0] active_table
);

    logic [N_IN-1:0]  wr_idx;
    logic [TBL_W-1:0] shadow;
    logic [TBL_W-1:0] shadow_nxt;

    always_comb begin
        shadow_nxt         = shadow;
        shadow_nxt[wr_idx] = load_bit;
        commit             = load_accept && (wr_idx == '1);
    end

    // wr_idx wraps back to 0 naturally after the final index, ready for the next load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx       <= '0;
            shadow       <= '0;
            active_table <= '0;
        end else if (load_accept) begin
            wr_idx <= wr_idx + 1'b1;
            shadow <= shadow_nxt;
            if (commit) begin
                active_table <= shadow_nxt;
            end
        end
    end

endmodule

// File: rtl/boolean_table_engine.sv
// Programmable N_IN-input boolean function: serial table load, registered lookup,
// and a full sweep that reports every entry and the number of minterms.
module boolean_table_engine
    import bool_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    localparam int unsigned TBL_W = tbl_w(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    input  logic            load_bit,
    output logic            load_ready,
    input  logic [N_IN-1:0] x,
    output logic            y,
    input  logic            start,
    output logic            busy,
    output logic            sweep_valid,
    output logic [N_IN-1:0] sweep_idx,
    output logic            sweep_y,
    output logic            done,
    output logic [N_IN:0]   minterm_count
);

    state_t           state;
    state_t           state_nxt;
    logic             load_accept;
    logic             commit;
    logic [TBL_W-1:0] active_table;
    logic [N_IN:0]    run_count;
    logic [N_IN:0]    swept_count;

    truth_table_store #(
        .N_IN(N_IN)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .load_accept (load_accept),
        .load_bit    (load_bit),
        .commit      (commit),
        .active_table(active_table)
    );

    always_comb begin
        load_ready  = (state == ST_IDLE) || (state == ST_LOAD);
        busy        = (state == ST_LOAD) || (state == ST_SWEEP);
        sweep_valid = (state == ST_SWEEP);
        done        = (state == ST_DONE);
        sweep_y     = sweep_valid && active_table[sweep_idx];
        load_accept = load_valid && load_ready;
        swept_count = run_count + (N_IN+1)'(active_table[sweep_idx]);
    end

    // A load request in IDLE takes priority over start
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load_valid) begin
                    state_nxt = ST_LOAD;
                end else if (start) begin
                    state_nxt = ST_SWEEP;
                end
            end
            ST_LOAD: begin
                if (commit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (sweep_idx == '1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            y             <= 1'b0;
            sweep_idx     <= '0;
            run_count     <= '0;
            minterm_count <= '0;
        end else begin
            state <= state_nxt;
            y     <= active_table[x];
            if (state == ST_IDLE && state_nxt == ST_SWEEP) begin
                sweep_idx <= '0;
                run_count <= '0;
            end else if (state == ST_SWEEP) begin
                sweep_idx <= sweep_idx + 1'b1;
                run_count <= swept_count;
                if (sweep_idx == '1) begin
                    minterm_count <= swept_count;
                end
            end
        end
    end

endmodule

// File: tb/tb_boolean_table_engine.sv
// Scoreboard bench for boolean_table_engine: stimulus queues expected y / sweep / count
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_boolean_table_engine;

    localparam int unsigned N_IN = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_valid;
    logic            load_bit;
    logic            load_ready;
    logic [N_IN-1:0] x;
    logic            y;
    logic            start;
    logic            busy;
    logic            sweep_valid;
    logic [N_IN-1:0] sweep_idx;
    logic            sweep_y;
    logic            done;
    logic [N_IN:0]   minterm_count;

    int total = 0;
    int bad   = 0;

    logic y_chk = 1'b0;
    int   y_q[$];
    int   sidx_q[$];
    int   sy_q[$];
    int   cnt_q[$];

    boolean_table_engine #(
        .N_IN(N_IN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_bit     (load_bit),
        .load_ready   (load_ready),
        .x            (x),
        .y            (y),
        .start        (start),
        .busy         (busy),
        .sweep_valid  (sweep_valid),
        .sweep_idx    (sweep_idx),
        .sweep_y      (sweep_y),
        .done         (done),
        .minterm_count(minterm_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (y_chk) begin
                    if (y_q.size() == 0) check("y_queue_empty", 1, 0);
                    else check("y", int'(y), y_q.pop_front());
                end
                if (sweep_valid) begin
                    if (sidx_q.size() == 0) begin
                        check("unexpected_sweep_valid", 1, 0);
                    end else begin
                        check("sweep_idx", int'(sweep_idx), sidx_q.pop_front());
                        check("sweep_y", int'(sweep_y), sy_q.pop_front());
                    end
                end
                if (done) begin
                    if (cnt_q.size() == 0) check("unexpected_done", 1, 0);
                    else check("minterm_count_at_done", int'(minterm_count), cnt_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        y_chk = 1'b0;
    endtask

    task automatic tick_y(input int exp);
        @(posedge clk);
        #1;
        y_q.push_back(exp);
        y_chk = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        y_q.delete();
        sidx_q.delete();
        sy_q.delete();
        cnt_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Load a full table; y is expected to follow the old table through the final beat
    task automatic load_tbl(input logic [15:0] t, input logic [15:0] old,
                            input bit gaps, input bit with_start);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    load_valid = 1'b0;
                    tick_y(int'(old[x]));
                end
            end
            load_valid = 1'b1;
            load_bit   = t[i];
            start      = with_start && (i == 0);
            tick_y(int'(old[x]));
            start = 1'b0;
            if (with_start && i == 0) begin
                check("load_wins_no_sweep", int'(sweep_valid), 0);
                check("load_wins_busy", int'(busy), 1);
            end
        end
        load_valid = 1'b0;
        tick();
        check("busy_after_load", int'(busy), 0);
    endtask

    task automatic sweep(input logic [15:0] t, input int cnt, input bit glitch);
        for (int i = 0; i < 16; i++) begin
            sidx_q.push_back(i);
            sy_q.push_back(int'(t[i]));
        end
        cnt_q.push_back(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (glitch && k == 4) begin
                check("busy_in_sweep", int'(busy), 1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (sidx_q.size() == 0 && cnt_q.size() == 0) break;
        end
        start = 1'b0;
        check("sweep_drained", sidx_q.size() + cnt_q.size(), 0);
        repeat (3) tick();
        check("minterm_count_stable", int'(minterm_count), cnt);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_bit   = 1'b0;
        start      = 1'b0;
        x          = '0;
        #2;
        check("rst_y", int'(y), 0);
        check("rst_sweep_valid", int'(sweep_valid), 0);
        check("rst_sweep_idx", int'(sweep_idx), 0);
        check("rst_sweep_y", int'(sweep_y), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_minterm_count", int'(minterm_count), 0);
        check("rst_load_ready", int'(load_ready), 1);
        do_reset();

        // 16'h8934: ones at indices 2,4,5,8,11,15
        x = 4'h0;
        load_tbl(16'h8934, 16'h0000, 1'b0, 1'b0);
        x = 4'h4;
        tick_y(1);
        x = 4'h3;
        tick_y(0);
        tick();
        sweep(16'h8934, 6, 1'b1);

        // All-ones with gaps; x=3 is 0 in the old table and 1 in the new one
        x = 4'h3;
        load_tbl(16'hFFFF, 16'h8934, 1'b1, 1'b0);
        tick_y(1);
        tick();
        sweep(16'hFFFF, 16, 1'b0);

        do_reset();
        check("minterm_count_after_rst", int'(minterm_count), 0);
        sweep(16'h0000, 0, 1'b0);

        // Start raised together with the first load beat
        x = 4'h4;
        load_tbl(16'h0F0F, 16'h0000, 1'b0, 1'b1);
        x = 4'h0;
        tick_y(1);
        x = 4'h4;
        tick_y(0);
        tick();
        sweep(16'h0F0F, 8, 1'b0);

        // Reset after 7 beats discards the partial load
        do_reset();
        x = 4'h6;
        for (int i = 0; i < 7; i++) begin
            load_valid = 1'b1;
            load_bit   = 1'b1;
            tick_y(0);
        end
        load_valid = 1'b0;
        do_reset();
        tick_y(0);
        check("load_ready_after_abort", int'(load_ready), 1);
        check("busy_after_abort", int'(busy), 0);
        sweep(16'h0000, 0, 1'b0);

        // Reset mid-sweep: sweep_valid drops at once, no done pulse follows
        x = 4'h0;
        load_tbl(16'h8934, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            sidx_q.push_back(i);
            sy_q.push_back(int'(i == 2 || i == 4 || i == 5 || i == 8 || i == 11 || i == 15));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("rst_mid_sweep_valid", int'(sweep_valid), 0);
        check("rst_mid_sweep_done", int'(done), 0);
        sidx_q.delete();
        sy_q.delete();
        cnt_q.delete();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        x = 4'h4;
        tick_y(0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
